// File: rtl/input_conditioner_pkg.sv
// Shared helpers for the input conditioner: default geometry and
// the filter-counter width function used by every channel.
package input_conditioner_pkg;

    localparam int IC_DEF_CHANNELS      = 2;
    localparam int IC_DEF_SYNC_STAGES   = 2;
    localparam int IC_DEF_FILTER_CYCLES = 4;

    // Counter must hold FILTER_CYCLES-1; width covers FILTER_CYCLES too.
    function automatic int ic_cnt_width(input int filter_cycles);
        int w;
        w = $clog2(filter_cycles + 1);
        if (w < 1) begin
            w = 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/input_conditioner_channel.sv
// One conditioned input: synchronizer chain, stability filter,
// polarity normalisation and registered edge pulses.
module input_conditioner_channel
    import input_conditioner_pkg::*;
#(
    parameter int   SYNC_STAGES   = IC_DEF_SYNC_STAGES,
    parameter int   FILTER_CYCLES = IC_DEF_FILTER_CYCLES,
    parameter logic INVERT_BIT    = 1'b1,
    parameter logic INIT_BIT      = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic in_raw,
    output logic level,
    output logic assert_pulse,
    output logic deassert_pulse
);

    localparam int CW = ic_cnt_width(FILTER_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(FILTER_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;
    logic                   state_q;
    logic                   state_d;
    logic [CW-1:0]          cnt_q;
    logic [CW-1:0]          cnt_d;
    logic                   asrt_q;
    logic                   asrt_d;
    logic                   dasrt_q;
    logic                   dasrt_d;
    logic                   sync;

    assign sync = sync_q[SYNC_STAGES-1];

    always_comb begin
        sync_d  = {sync_q[SYNC_STAGES-2:0], in_raw};
        state_d = state_q;
        cnt_d   = '0;
        asrt_d  = 1'b0;
        dasrt_d = 1'b0;
        // Any cycle agreeing with the state restarts the stability count.
        if (sync != state_q) begin
            if (cnt_q == CNT_MAX) begin
                state_d = sync;
                asrt_d  = sync ^ INVERT_BIT;
                dasrt_d = ~(sync ^ INVERT_BIT);
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q  <= {SYNC_STAGES{INIT_BIT}};
            state_q <= INIT_BIT;
            cnt_q   <= '0;
            asrt_q  <= 1'b0;
            dasrt_q <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            asrt_q  <= asrt_d;
            dasrt_q <= dasrt_d;
        end
    end

    assign level          = state_q ^ INVERT_BIT;
    assign assert_pulse   = asrt_q;
    assign deassert_pulse = dasrt_q;

endmodule

// File: rtl/input_conditioner.sv
// Multi-channel input conditioner for reset/NMI/button style inputs;
// each channel is independent and identical apart from polarity/init.
module input_conditioner
    import input_conditioner_pkg::*;
#(
    parameter int                  CHANNELS      = IC_DEF_CHANNELS,
    parameter int                  SYNC_STAGES   = IC_DEF_SYNC_STAGES,
    parameter int                  FILTER_CYCLES = IC_DEF_FILTER_CYCLES,
    parameter logic [CHANNELS-1:0] INVERT        = {CHANNELS{1'b1}},
    parameter logic [CHANNELS-1:0] INIT          = {CHANNELS{1'b1}}
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [CHANNELS-1:0] in_raw,
    output logic [CHANNELS-1:0] level,
    output logic [CHANNELS-1:0] assert_pulse,
    output logic [CHANNELS-1:0] deassert_pulse
);

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        input_conditioner_channel #(
            .SYNC_STAGES  (SYNC_STAGES),
            .FILTER_CYCLES(FILTER_CYCLES),
            .INVERT_BIT   (INVERT[i]),
            .INIT_BIT     (INIT[i])
        ) u_ch (
            .clk           (clk),
            .reset         (reset),
            .in_raw        (in_raw[i]),
            .level         (level[i]),
            .assert_pulse  (assert_pulse[i]),
            .deassert_pulse(deassert_pulse[i])
        );
    end

endmodule

// File: tb/tb_input_conditioner.sv
// Directed bench for input_conditioner: default 2-channel instance
// plus a 4-channel, 3-stage, unfiltered, mixed-polarity instance.
module tb_input_conditioner;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] in_raw;
    logic [1:0] level;
    logic [1:0] asrt;
    logic [1:0] dasrt;
    logic [3:0] in_raw_p;
    logic [3:0] level_p;
    logic [3:0] asrt_p;
    logic [3:0] dasrt_p;

    int vec = 0;
    int err = 0;

    always #5 clk = ~clk;

    input_conditioner dut (
        .clk           (clk),
        .reset         (reset),
        .in_raw        (in_raw),
        .level         (level),
        .assert_pulse  (asrt),
        .deassert_pulse(dasrt)
    );

    input_conditioner #(
        .CHANNELS     (4),
        .SYNC_STAGES  (3),
        .FILTER_CYCLES(1),
        .INVERT       (4'b0101)
    ) dut_p (
        .clk           (clk),
        .reset         (reset),
        .in_raw        (in_raw_p),
        .level         (level_p),
        .assert_pulse  (asrt_p),
        .deassert_pulse(dasrt_p)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset    = 1'b1;
        in_raw   = 2'b00;
        in_raw_p = 4'hF;
        repeat (3) tick();
        vec++;
        if (level !== 2'b00) begin
            err++;
            $display("FAIL rst_level got=%b exp=00", level);
        end
        vec++;
        if (asrt !== 2'b00 || dasrt !== 2'b00) begin
            err++;
            $display("FAIL rst_pulse got=%b/%b exp=00/00", asrt, dasrt);
        end
        vec++;
        if (level_p !== 4'b1010) begin
            err++;
            $display("FAIL rst_level_p got=%b exp=1010", level_p);
        end
        reset = 1'b0;
        for (int e = 1; e <= 7; e++) begin
            logic [1:0] el;
            logic [1:0] ea;
            tick();
            el = (e >= 6) ? 2'b11 : 2'b00;
            ea = (e == 6) ? 2'b11 : 2'b00;
            vec++;
            if (level !== el || asrt !== ea || dasrt !== 2'b00) begin
                err++;
                $display("FAIL rel_e%0d got=%b/%b/%b exp=%b/%b/00",
                         e, level, asrt, dasrt, el, ea);
            end
        end
    endtask

    task automatic test_latency();
        in_raw = 2'b11;
        repeat (10) tick();
        vec++;
        if (level !== 2'b00) begin
            err++;
            $display("FAIL lat_settle got=%b exp=00", level);
        end
        in_raw[0] = 1'b0;
        for (int e = 1; e <= 7; e++) begin
            logic el;
            logic ea;
            tick();
            el = (e >= 6);
            ea = (e == 6);
            vec++;
            if (level[0] !== el || asrt[0] !== ea || level[1] !== 1'b0) begin
                err++;
                $display("FAIL lat_e%0d got=%b/%b exp=%b/%b",
                         e, level, asrt[0], {1'b0, el}, ea);
            end
        end
    endtask

    task automatic test_glitch();
        in_raw[1] = 1'b0;
        repeat (3) tick();
        in_raw[1] = 1'b1;
        for (int e = 1; e <= 10; e++) begin
            tick();
            vec++;
            if (level[1] !== 1'b0 || asrt[1] !== 1'b0 || dasrt[1] !== 1'b0) begin
                err++;
                $display("FAIL glitch3_e%0d got=%b/%b/%b exp=0/0/0",
                         e, level[1], asrt[1], dasrt[1]);
            end
        end
        in_raw[1] = 1'b0;
        for (int e = 1; e <= 12; e++) begin
            logic el;
            logic ea;
            logic ed;
            tick();
            if (e == 4) in_raw[1] = 1'b1;
            el = (e >= 6 && e < 10);
            ea = (e == 6);
            ed = (e == 10);
            vec++;
            if (level[1] !== el || asrt[1] !== ea || dasrt[1] !== ed) begin
                err++;
                $display("FAIL glitch4_e%0d got=%b/%b/%b exp=%b/%b/%b",
                         e, level[1], asrt[1], dasrt[1], el, ea, ed);
            end
        end
    endtask

    task automatic test_chatter();
        int n  = 0;
        int at = -1;
        int nd = 0;
        in_raw[0] = 1'b1;
        repeat (10) tick();
        vec++;
        if (level[0] !== 1'b0) begin
            err++;
            $display("FAIL chat_settle got=%b exp=0", level[0]);
        end
        for (int c = 1; c <= 60; c++) begin
            in_raw[0] = (c <= 40) ? (((c - 1) / 2) % 2 == 1) : 1'b0;
            tick();
            if (asrt[0] === 1'b1) begin
                n++;
                at = c;
            end
            if (dasrt[0] !== 1'b0) nd++;
        end
        vec++;
        if (n !== 1 || at !== 46) begin
            err++;
            $display("FAIL chat_pulse got=%0d@%0d exp=1@46", n, at);
        end
        vec++;
        if (nd !== 0 || level !== 2'b01) begin
            err++;
            $display("FAIL chat_end got=%0d/%b exp=0/01", nd, level);
        end
    endtask

    task automatic test_reset_mid();
        in_raw[1] = 1'b0;
        repeat (4) tick();
        reset = 1'b1;
        tick();
        vec++;
        if (level !== 2'b00 || asrt !== 2'b00 || dasrt !== 2'b00) begin
            err++;
            $display("FAIL midrst got=%b/%b/%b exp=00/00/00",
                     level, asrt, dasrt);
        end
        tick();
        reset = 1'b0;
        for (int e = 1; e <= 7; e++) begin
            logic [1:0] el;
            logic [1:0] ea;
            tick();
            el = (e >= 6) ? 2'b11 : 2'b00;
            ea = (e == 6) ? 2'b11 : 2'b00;
            vec++;
            if (level !== el || asrt !== ea || dasrt !== 2'b00) begin
                err++;
                $display("FAIL midrel_e%0d got=%b/%b/%b exp=%b/%b/00",
                         e, level, asrt, dasrt, el, ea);
            end
        end
    endtask

    task automatic test_param();
        vec++;
        if (level_p !== 4'b1010) begin
            err++;
            $display("FAIL par_pre got=%b exp=1010", level_p);
        end
        in_raw_p = 4'h0;
        for (int e = 1; e <= 5; e++) begin
            logic [3:0] el;
            logic [3:0] ea;
            logic [3:0] ed;
            tick();
            el = (e >= 4) ? 4'b0101 : 4'b1010;
            ea = (e == 4) ? 4'b0101 : 4'b0000;
            ed = (e == 4) ? 4'b1010 : 4'b0000;
            vec++;
            if (level_p !== el || asrt_p !== ea || dasrt_p !== ed) begin
                err++;
                $display("FAIL par_e%0d got=%b/%b/%b exp=%b/%b/%b",
                         e, level_p, asrt_p, dasrt_p, el, ea, ed);
            end
        end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_glitch();
        test_chatter();
        test_reset_mid();
        test_param();
        $display("== %0d vectors applied, %0d miscompares ==", vec, err);
        $finish;
    end

endmodule
